// File: rtl/rll27_decoder.sv
// rll27_decoder: serial RLL(2,7) channel-bit decoder.
// Shifts channel bits into an accumulator and resolves a codeword, a legal
// prefix or an illegal sequence at lengths 4, 6 and 8. Results are registered
// and strobed for one cycle.
// Optional: define RLL27_DEC_RLCHK_EN to add the run-length checker (rl_err_o).
module rll27_decoder #(
   parameter int unsigned MAXCODE = 8,
   parameter int unsigned MAXDATA = 4
) (
   input  logic               clk_i,
   input  logic               arst_i,
   input  logic               code_i,
   input  logic               code_valid_i,
   output logic [MAXDATA-1:0] data_o,
   output logic [2:0]         data_len_o,
   output logic               data_valid_o,
   output logic               err_o
`ifdef RLL27_DEC_RLCHK_EN
   ,
   output logic               rl_err_o
`endif
);

   logic [MAXCODE-1:0] r_acc;
   logic [3:0]         r_cnt;
   logic [MAXDATA-1:0] r_data;
   logic [2:0]         r_len;
   logic               r_dv;
   logic               r_err;

   logic [MAXCODE-1:0] w_next;
   logic [3:0]         w_cnt1;
   logic               w_hit;
   logic               w_bad;
   logic [MAXDATA-1:0] w_data;
   logic [2:0]         w_len;
   // The oldest accumulator bit is shifted out before any match looks at it.
   logic               w_unused;

   assign w_unused = r_acc[MAXCODE-1];

   // Classify the accumulator including the incoming bit: match, prefix or illegal.
   always_comb begin
      w_next = {r_acc[MAXCODE-2:0], code_i};
      w_cnt1 = r_cnt + 4'd1;
      w_hit  = 1'b0;
      w_bad  = 1'b0;
      w_data = '0;
      w_len  = 3'd0;
      case (w_cnt1)
         4'd4: begin
            case (w_next[3:0])
               4'b0100: begin w_hit = 1'b1; w_data = 4'b0010; w_len = 3'd2; end
               4'b1000: begin w_hit = 1'b1; w_data = 4'b0011; w_len = 3'd2; end
               4'b0000, 4'b0001, 4'b0010, 4'b1001: ;
               default: w_bad = 1'b1;
            endcase
         end
         4'd6: begin
            case (w_next[5:0])
               6'b000100: begin w_hit = 1'b1; w_data = 4'b0000; w_len = 3'd3; end
               6'b100100: begin w_hit = 1'b1; w_data = 4'b0010; w_len = 3'd3; end
               6'b001000: begin w_hit = 1'b1; w_data = 4'b0011; w_len = 3'd3; end
               6'b000010, 6'b001001: ;
               default: w_bad = 1'b1;
            endcase
         end
         4'd8: begin
            case (w_next)
               8'b00100100: begin w_hit = 1'b1; w_data = 4'b0010; w_len = 3'd4; end
               8'b00001000: begin w_hit = 1'b1; w_data = 4'b0011; w_len = 3'd4; end
               default:     w_bad = 1'b1;
            endcase
         end
         default: ;
      endcase
   end

   // Accumulator/counter update and registered one-cycle result strobes.
   always_ff @(posedge clk_i) begin
      if (arst_i) begin
         r_acc  <= '0;
         r_cnt  <= 4'd0;
         r_data <= '0;
         r_len  <= 3'd0;
         r_dv   <= 1'b0;
         r_err  <= 1'b0;
      end else begin
         r_data <= '0;
         r_len  <= 3'd0;
         r_dv   <= 1'b0;
         r_err  <= 1'b0;
         if (code_valid_i) begin
            if (w_hit || w_bad) begin
               r_acc <= '0;
               r_cnt <= 4'd0;
            end else begin
               r_acc <= w_next;
               r_cnt <= w_cnt1;
            end
            r_data <= w_data;
            r_len  <= w_len;
            r_dv   <= w_hit;
            r_err  <= w_bad;
         end
      end
   end

   assign data_o       = r_data;
   assign data_len_o   = r_len;
   assign data_valid_o = r_dv;
   assign err_o        = r_err;

`ifdef RLL27_DEC_RLCHK_EN
   logic [3:0] r_zc;
   logic       r_seen;
   logic       r_rl_err;

   // Run-length check on the raw stream: too few zeros between ones (d) or
   // an eighth consecutive zero (k); the counter saturates so k fires once per run.
   always_ff @(posedge clk_i) begin
      if (arst_i) begin
         r_zc     <= 4'd0;
         r_seen   <= 1'b0;
         r_rl_err <= 1'b0;
      end else begin
         r_rl_err <= 1'b0;
         if (code_valid_i) begin
            if (code_i) begin
               r_rl_err <= r_seen && (r_zc < 4'd2);
               r_zc     <= 4'd0;
               r_seen   <= 1'b1;
            end else begin
               if (r_zc != 4'hF) begin
                  r_zc <= r_zc + 4'd1;
               end
               r_rl_err <= r_seen && (r_zc == 4'd7);
            end
         end
      end
   end

   assign rl_err_o = r_rl_err;
`endif

endmodule

// File: tb/tb_rll27_decoder.sv
// tb_rll27_decoder: table-driven, directed and randomized checks of rll27_decoder.
module tb_rll27_decoder;

   logic       clk = 1'b0;
   logic       arst;
   logic       code;
   logic       cv;
   logic [3:0] data;
   logic [2:0] dlen;
   logic       dv;
   logic       err;
`ifdef RLL27_DEC_RLCHK_EN
   logic       rl;
`endif

   always #5 clk = ~clk;

   rll27_decoder dut (
      .clk_i        (clk),
      .arst_i       (arst),
      .code_i       (code),
      .code_valid_i (cv),
      .data_o       (data),
      .data_len_o   (dlen),
      .data_valid_o (dv),
      .err_o        (err)
`ifdef RLL27_DEC_RLCHK_EN
      ,
      .rl_err_o     (rl)
`endif
   );

   typedef struct {
      logic [7:0] code;
      int         clen;
      logic [3:0] data;
      int         dlen;
   } cw_t;

   typedef struct {
      logic [7:0] bits;
      int         n;
      logic [3:0] data;
      int         dlen;
      bit         err;
   } vec_t;

   cw_t  cwt[7];
   vec_t vt[12];

   int total = 0;
   int bad   = 0;

   // reference model state: pending channel bits as a number plus their count
   int m_val, m_len, m_zeros;
   bit m_seen;
   int e_dv, e_err, e_data, e_len, e_rl;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_step(input bit v, input bit b, input bit r);
      bit found, pre;
      e_dv = 0; e_err = 0; e_data = 0; e_len = 0; e_rl = 0;
      if (r) begin
         m_val = 0; m_len = 0; m_zeros = 0; m_seen = 0;
      end else if (v) begin
         m_val = m_val * 2 + int'(b);
         m_len++;
         if (b) begin
            e_rl    = int'(m_seen && m_zeros < 2);
            m_zeros = 0;
            m_seen  = 1;
         end else begin
            m_zeros++;
            e_rl = int'(m_seen && m_zeros == 8);
         end
         if (m_len == 4 || m_len == 6 || m_len == 8) begin
            found = 0;
            pre   = 0;
            for (int j = 0; j < 7; j++) begin
               if (cwt[j].clen == m_len && int'(cwt[j].code) == m_val) begin
                  found  = 1;
                  e_dv   = 1;
                  e_data = int'(cwt[j].data);
                  e_len  = cwt[j].dlen;
               end
               if (cwt[j].clen > m_len && (int'(cwt[j].code) >> (cwt[j].clen - m_len)) == m_val)
                  pre = 1;
            end
            if (!found && !pre) e_err = 1;
            if (found || !pre) begin
               m_val = 0;
               m_len = 0;
            end
         end
      end
   endtask

   task automatic drive(input bit v, input bit b, input bit r);
      cv   = v;
      code = b;
      arst = r;
      @(posedge clk);
      #1;
      model_step(v, b, r);
   endtask

   task automatic cmp_model(input string tag);
      chk({tag, "_dv"}, int'(dv), e_dv);
      chk({tag, "_err"}, int'(err), e_err);
      chk({tag, "_data"}, int'(data), e_data);
      chk({tag, "_len"}, int'(dlen), e_len);
`ifdef RLL27_DEC_RLCHK_EN
      chk({tag, "_rl"}, int'(rl), e_rl);
`endif
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_quiet"}, int'({dv, err, data, dlen}), 0);
   endtask

   initial begin
      logic [7:0] w;
      int         r, idx, tries;

      cwt[0] = '{8'b0100,     4, 4'b0010, 2};
      cwt[1] = '{8'b1000,     4, 4'b0011, 2};
      cwt[2] = '{8'b000100,   6, 4'b0000, 3};
      cwt[3] = '{8'b100100,   6, 4'b0010, 3};
      cwt[4] = '{8'b001000,   6, 4'b0011, 3};
      cwt[5] = '{8'b00100100, 8, 4'b0010, 4};
      cwt[6] = '{8'b00001000, 8, 4'b0011, 4};

      vt[0]  = '{8'b0100,     4, 4'b0010, 2, 1'b0};
      vt[1]  = '{8'b1000,     4, 4'b0011, 2, 1'b0};
      vt[2]  = '{8'b000100,   6, 4'b0000, 3, 1'b0};
      vt[3]  = '{8'b100100,   6, 4'b0010, 3, 1'b0};
      vt[4]  = '{8'b00001000, 8, 4'b0011, 4, 1'b0};
      vt[5]  = '{8'b00100100, 8, 4'b0010, 4, 1'b0};
      vt[6]  = '{8'b001000,   6, 4'b0011, 3, 1'b0};
      vt[7]  = '{8'b1100,     4, 4'b0000, 0, 1'b1};
      vt[8]  = '{8'b0100,     4, 4'b0010, 2, 1'b0};
      vt[9]  = '{8'b000000,   6, 4'b0000, 0, 1'b1};
      vt[10] = '{8'b00100101, 8, 4'b0000, 0, 1'b1};
      vt[11] = '{8'b0111,     4, 4'b0000, 0, 1'b1};

      cv = 1'b0; code = 1'b0; arst = 1'b1;
      m_val = 0; m_len = 0; m_zeros = 0; m_seen = 0;

      // reset state, with valid high to show reset wins
      drive(1, 1, 1);
      drive(1, 0, 1);
      chk_quiet("reset");

      // table: continuous back-to-back words
      for (int k = 0; k < 12; k++) begin
         w = vt[k].bits;
         for (int i = vt[k].n - 1; i >= 0; i--) begin
            drive(1, w[i], 0);
`ifdef RLL27_DEC_RLCHK_EN
            if (k < 4) chk("tbl_rl", int'(rl), 0);
`endif
            if (i > 0) begin
               chk_quiet("tbl_mid");
            end else begin
               chk("tbl_dv", int'(dv), int'(!vt[k].err));
               chk("tbl_err", int'(err), int'(vt[k].err));
               chk("tbl_data", int'(data), int'(vt[k].data));
               chk("tbl_len", int'(dlen), vt[k].dlen);
            end
         end
      end

      // gap inside 100100
      drive(1, 1, 0); chk_quiet("gap_b1");
      drive(1, 0, 0); chk_quiet("gap_b2");
      for (int g = 0; g < 3; g++) begin
         drive(0, 1'($urandom_range(0, 1)), 0);
         chk_quiet("gap_idle");
      end
      drive(1, 0, 0); chk_quiet("gap_b3");
      drive(1, 1, 0); chk_quiet("gap_b4");
      drive(1, 0, 0); chk_quiet("gap_b5");
      drive(1, 0, 0);
      chk("gap_dv", int'(dv), 1);
      chk("gap_data", int'(data), 2);
      chk("gap_len", int'(dlen), 3);
      chk("gap_err", int'(err), 0);
      drive(0, 0, 0); chk_quiet("strobe_drop");

      // reset mid-codeword discards partial bits silently
      drive(1, 0, 0);
      drive(1, 0, 0);
      drive(1, 0, 0);
      drive(1, 0, 1); chk_quiet("midrst");
      drive(1, 1, 0); chk_quiet("rst_b1");
      drive(1, 0, 0); chk_quiet("rst_b2");
      drive(1, 0, 0); chk_quiet("rst_b3");
      drive(1, 0, 0);
      chk("rst_dv", int'(dv), 1);
      chk("rst_data", int'(data), 3);
      chk("rst_len", int'(dlen), 2);
      chk("rst_err", int'(err), 0);

      // randomized mix of codewords, gaps, junk bits and resets vs the model
      drive(0, 0, 1);
      cmp_model("rnd_rst");
      tries = 0;
      while (tries < 400) begin
         tries++;
         r = $urandom_range(0, 99);
         if (r < 3) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);
            cmp_model("rnd_rst");
         end else if (r < 18) begin
            drive(0, 1'($urandom_range(0, 1)), 0);
            cmp_model("rnd_idle");
         end else if (r < 26) begin
            drive(1, 1'($urandom_range(0, 1)), 0);
            cmp_model("rnd_junk");
         end else begin
            idx = $urandom_range(0, 6);
            w   = cwt[idx].code;
            for (int i = cwt[idx].clen - 1; i >= 0; i--) begin
               if ($urandom_range(0, 9) < 2) begin
                  drive(0, 1'($urandom_range(0, 1)), 0);
                  cmp_model("rnd_gap");
               end
               drive(1, w[i], 0);
               cmp_model("rnd_cw");
            end
         end
      end

`ifdef RLL27_DEC_RLCHK_EN
      // run-length checker: k violation after 8 zeros, then d violation on 1 0 1
      drive(0, 0, 1);
      drive(1, 1, 0); chk("rl_first1", int'(rl), 0);
      for (int z = 1; z <= 8; z++) begin
         drive(1, 0, 0);
         chk("rl_zero", int'(rl), (z == 8) ? 1 : 0);
      end
      drive(1, 0, 0); chk("rl_zero9", int'(rl), 0);
      drive(1, 1, 0); chk("rl_long1", int'(rl), 0);
      drive(1, 0, 0); chk("rl_short0", int'(rl), 0);
      drive(1, 1, 0); chk("rl_d_viol", int'(rl), 1);
      drive(0, 0, 0); chk("rl_drop", int'(rl), 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rll27_decoder.md
Name: rll27_decoder

Overview:
- Downstream stage of the RLL(2,7) encoder. Consumes the serial channel-bit stream the encoder produces and recovers the original data words.
- Decoding works by accumulating channel bits until they match a codeword. Each decoded data word (2, 3 or 4 bits) is emitted in parallel with its length and a one-cycle valid strobe.
- Invalid channel sequences are flagged and the decoder resynchronises on the next bit.

Parameters:
- MAXCODE, 8, maximum codeword length in channel bits. Fixed by the code table; not to be overridden.
- MAXDATA, 4, maximum data-word length in bits; sets the width of data_o.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- arst_i  input  1  reset. Synchronous, active-high, sampled on rising clk_i.
- code_i  input  1  channel bit, MSB of codeword first.
- code_valid_i  input  1  code_i is sampled only when this is high.
- data_o  output  4  decoded word, right-aligned; first data bit is at data_o[data_len_o-1]; unused upper bits are 0.
- data_len_o  output  3  valid length of data_o: 2, 3 or 4. Value is 0 when data_valid_o is low.
- data_valid_o  output  1  one-cycle strobe: data_o and data_len_o are valid.
- err_o  output  1  one-cycle strobe: illegal codeword detected.

Behaviour:
- Code table (channel -> data):
  - 0100->10
  - 1000->11
  - 000100->000
  - 100100->010
  - 001000->011
  - 00100100->0010
  - 00001000->0011
- The code is prefix-free.
- State:
  - 8-bit shift register acc (new bit enters at LSB).
  - 4-bit counter cnt (0..8).
- Each cycle with code_valid_i=1:
  - acc <= {acc[6:0], code_i}; cnt <= cnt+1.
  - Matching runs combinationally on the next-state value {acc, code_i} at count cnt+1.
- Match check, performed only when cnt+1 is 4, 6 or 8:
  - If the low cnt+1 bits equal a codeword: next edge sets data_valid_o=1, data_o and data_len_o per table; acc and cnt are cleared.
  - If the bits are neither a codeword nor a proper prefix of one: next edge sets err_o=1; acc and cnt are cleared; no data output.
  - Legal 4-bit prefixes: 0000, 0001, 0010, 1001.
  - Legal 6-bit prefixes: 000010, 001001.
  - At 8 bits, any non-match is an error.
- Latency: outputs are registered and appear exactly one cycle after the clock edge that samples the last channel bit of the codeword.
- data_valid_o and err_o are never high together. Both deassert the following cycle unless retriggered.
- code_valid_i=0: acc and cnt hold; strobes drop to 0; data_o/data_len_o return to 0.
- Back-to-back codewords with no gap decode with no bubble.
- Reset (arst_i=1, overrides code_valid_i):
  - acc=0, cnt=0.
  - data_o=0, data_len_o=0, data_valid_o=0, err_o=0.
  - Reset mid-codeword discards the partial codeword without raising err_o.
- cnt never exceeds 8; reaching 8 always resolves to a match or an error.

Optional Feature:
- Macro: RLL27_DEC_RLCHK_EN.
- With the macro defined, a run-length checker is added on the raw channel stream:
  - Adds output rl_err_o (1 bit, reset 0, one-cycle strobe, registered, same latency as err_o).
  - A saturating 4-bit zero counter tracks zeros since the last 1; a flag records that a 1 has been seen since reset.
  - On a sampled 1 with flag set and zero count <2: rl_err_o pulses (d violation).
  - On the 8th consecutive sampled 0 with flag set: rl_err_o pulses once per run (k violation).
  - The checker never alters decoding.
- Without the macro: no rl_err_o port and no checker logic.

Test Plan:
- Channel stream 0100 1000 000100 100100, continuous valid -> four strobes: (10,len2), (11,len2), (000,len3), (010,len3), each 1 cycle after the word's last bit; no err_o.
- Stream 00001000 00100100 001000 -> (0011,4), (0010,4), (011,3); cnt reaches 8 with no error.
- Stream 1100 then 0100 -> err_o pulses after the 4th bit with no data strobe; then (10,len2) decodes cleanly.
- Stream 100100 with code_valid_i low for 3 cycles between bits 2 and 3 -> single strobe (010,len3); strobes 0 during the gap.
- Bits 000 then arst_i for 1 cycle, then 1000 -> all outputs 0 during reset; then (11,len2) with no err_o.
- (RLL27_DEC_RLCHK_EN) Stream 1 0 1 -> rl_err_o pulses. Stream 1 followed by 8 zeros -> one rl_err_o pulse after the 8th zero. Legal stream from the first scenario -> rl_err_o stays 0.
